// File: rtl/frame_stream_reader.sv
// Streams one DEPTH-word frame out of a synchronous-read sample memory as valid/ready
// words, using a 2-entry output FIFO so that downstream stalls never drop data.
//
// state    | meaning
// ST_IDLE  | waiting for start_i; a start issues the read of address 0 in the same cycle
// ST_READ  | issuing reads 1..DEPTH-1 while FIFO occupancy plus reads in flight allows it
// ST_DRAIN | all reads issued; waiting for the handshake of the last-tagged word
module frame_stream_reader #(
   parameter int  WORD_SIZE = 16,
   parameter int  DEPTH     = 10,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 mem_rd_en_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   input  logic [WORD_SIZE-1:0] mem_data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [WORD_SIZE-1:0] data_o,
   output logic                 last_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  infl_q, infl_last_q;
   logic [WORD_SIZE-1:0]  fifo_data_q [2];
   logic                  fifo_last_q [2];
   logic                  rd_ptr_q, wr_ptr_q;
   logic [1:0]            count_q;
   logic                  done_q, done_d;
   logic                  rd_en, push, pop, credit_ok;
   logic [1:0]            occ_after;

   assign push      = infl_q;
   assign pop       = (count_q != 2'd0) && ready_i;
   // A word popped this cycle frees its slot in time for a read issued now,
   // which is what sustains one word per cycle with ready_i held high.
   assign occ_after = count_q - {1'b0, pop} + {1'b0, infl_q};
   assign credit_ok = occ_after < 2'd2;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_en   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               rd_en   = 1'b1;
               addr_d  = ADDR_W'(1);
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (credit_ok) begin
               rd_en = 1'b1;
               if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
               else                     addr_d  = addr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (pop && fifo_last_q[rd_ptr_q]) begin
               state_d = ST_IDLE;
               addr_d  = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         done_q      <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         infl_q      <= rd_en;
         infl_last_q <= rd_en && (addr_q == LAST_ADDR);
         done_q      <= done_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_data_i;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(push && !pop && (count_q == 2'd2)));

   assign busy_o      = (state_q != ST_IDLE);
   assign mem_rd_en_o = rd_en;
   assign mem_addr_o  = addr_q;
   assign valid_o     = (count_q != 2'd0);
   assign data_o      = fifo_data_q[rd_ptr_q];
   assign last_o      = valid_o && fifo_last_q[rd_ptr_q];
   assign done_o      = done_q;

endmodule
